// File: rtl/jam_cost_server.sv
// Responder for the JAM cost-query interface: 8x8 cost table loaded by a valid/ready stream, async query read, result capture.
// Optional query-change counter output query_cnt is built only when JCS_QUERY_CNT_EN is defined.
module jam_cost_server #(
    parameter int CW  = 7,
    parameter int QCW = 16
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          load_valid,
    input  logic [CW-1:0] load_data,
    output logic          load_ready,
    input  logic          reload,
    input  logic [2:0]    W,
    input  logic [2:0]    J,
    output logic [CW-1:0] Cost,
    input  logic          Valid,
    input  logic [3:0]    MatchCount,
    input  logic [9:0]    MinCost,
    output logic          table_rdy,
    output logic          done,
    output logic [3:0]    res_match,
    output logic [9:0]    res_min,
    output logic          proto_err
`ifdef JCS_QUERY_CNT_EN
    ,
    output logic [QCW-1:0] query_cnt
`endif
);

    typedef enum logic [1:0] {
        S_EMPTY   = 2'd0,
        S_LOADING = 2'd1,
        S_READY   = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t        state;
    logic [5:0]    load_ptr;
    logic [CW-1:0] cost_tab [64];
    logic          beat;
    logic          in_load_phase;
    logic          in_query_phase;

    // reload takes priority over a coincident load beat, so the beat is dropped
    assign beat           = load_valid & load_ready & ~reload;
    assign in_load_phase  = (state == S_EMPTY) || (state == S_LOADING);
    assign in_query_phase = (state == S_READY) || (state == S_DONE);

    // Table storage is plain RAM: written by accepted beats, never reset
    always_ff @(posedge CLK) begin
        if (beat) begin
            cost_tab[load_ptr] <= load_data;
        end
    end

    always_comb begin
        Cost = '0;
        if (table_rdy) begin
            Cost = cost_tab[{W, J}];
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= S_EMPTY;
            load_ptr   <= '0;
            load_ready <= 1'b1;
            table_rdy  <= 1'b0;
            done       <= 1'b0;
            res_match  <= '0;
            res_min    <= '0;
            proto_err  <= 1'b0;
        end else begin
            if ((Valid && in_load_phase) || (load_valid && in_query_phase)) begin
                proto_err <= 1'b1;
            end
            if (reload) begin
                state      <= S_EMPTY;
                load_ptr   <= '0;
                load_ready <= 1'b1;
                table_rdy  <= 1'b0;
                done       <= 1'b0;
            end else begin
                case (state)
                    S_EMPTY, S_LOADING: begin
                        if (beat) begin
                            load_ptr <= load_ptr + 6'd1;
                            if (load_ptr == 6'd63) begin
                                state      <= S_READY;
                                load_ready <= 1'b0;
                                table_rdy  <= 1'b1;
                            end else begin
                                state <= S_LOADING;
                            end
                        end
                    end
                    S_READY: begin
                        if (Valid) begin
                            state     <= S_DONE;
                            done      <= 1'b1;
                            res_match <= MatchCount;
                            res_min   <= MinCost;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

`ifdef JCS_QUERY_CNT_EN
    logic [5:0] prev_wj;
    logic       was_ready;

    // A change is counted against the previous posedge sample; entering READY always counts
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            query_cnt <= '0;
            prev_wj   <= '0;
            was_ready <= 1'b0;
        end else begin
            prev_wj   <= {W, J};
            was_ready <= (state == S_READY);
            if (reload) begin
                query_cnt <= '0;
            end else if ((state == S_READY) && (!was_ready || ({W, J} != prev_wj))
                         && (query_cnt != {QCW{1'b1}})) begin
                query_cnt <= query_cnt + 1'b1;
            end
        end
    end
`endif

endmodule
